// File: rtl/gs_lsu.sv
`default_nettype none
// ============================================================================
// Module   : gs_lsu
// Brief    : Load/store unit between EX and a req/gnt/rvalid data bus.
//            Generates byte enables and lane-aligned store data, and aligns
//            and sign/zero-extends load data for write-back. Exactly one
//            bus transaction can be in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module gs_lsu #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int BYTES     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid_i,
    input  logic                 ex_MemRead_i,
    input  logic                 ex_MemWrite_i,
    input  logic [ADDR_SIZE-1:0] ex_addr_i,
    input  logic [WORD_SIZE-1:0] ex_wdata_i,
    input  logic [1:0]           ex_size_i,
    input  logic                 ex_unsigned_i,
    input  logic                 flush_i,
    output logic                 lsu_ready_o,
    output logic                 data_req_o,
    output logic                 data_we_o,
    output logic [BYTES-1:0]     data_be_o,
    output logic [ADDR_SIZE-1:0] data_addr_o,
    output logic [WORD_SIZE-1:0] data_wdata_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [WORD_SIZE-1:0] data_rdata_i,
    output logic                 lsu_rvalid_o,
    output logic                 lsu_busy_o,
    output logic [WORD_SIZE-1:0] lsu_rdata_o,
    output logic                 lsu_misalign_o
);

    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               state_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic                 we_q;
    logic [BYTES-1:0]     be_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [1:0]           size_q;
    logic                 unsigned_q;
    logic [OFF_W-1:0]     off_q;
    logic                 rvalid_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 misalign_q;

    logic                 accept_d;
    logic                 misalign_d;
    logic [OFF_W-1:0]     off_d;
    logic [BYTES-1:0]     be_d;
    logic [WORD_SIZE-1:0] wdata_d;
    logic [WORD_SIZE-1:0] shifted_d;
    logic [WORD_SIZE-1:0] load_d;

    assign off_d    = ex_addr_i[OFF_W-1:0];
    assign accept_d = ex_valid_i & (ex_MemRead_i | ex_MemWrite_i) & ~flush_i;

    // Decode the incoming op: alignment check, byte lanes and replicated store data.
    always_comb begin
        misalign_d = 1'b0;
        be_d       = '1;
        wdata_d    = ex_wdata_i;
        case (ex_size_i)
            2'b00: begin
                be_d    = {{(BYTES-1){1'b0}}, 1'b1} << off_d;
                wdata_d = {BYTES{ex_wdata_i[7:0]}};
            end
            2'b01: begin
                misalign_d = off_d[0];
                be_d       = {{(BYTES-2){1'b0}}, 2'b11} << off_d;
                wdata_d    = {(BYTES/2){ex_wdata_i[15:0]}};
            end
            2'b10: begin
                misalign_d = (off_d != '0);
            end
            default: begin
                misalign_d = 1'b1;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0 and extend to a full word.
    always_comb begin
        shifted_d = data_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_d = {{(WORD_SIZE-8){~unsigned_q & shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   load_d = {{(WORD_SIZE-16){~unsigned_q & shifted_d[15]}}, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    // Transaction FSM; the op is latched on acceptance so EX may move on freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            off_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        if (misalign_d) begin
                            misalign_q <= 1'b1;
                        end else begin
                            addr_q     <= {ex_addr_i[ADDR_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                            we_q       <= ex_MemWrite_i;
                            be_q       <= be_d;
                            wdata_q    <= wdata_d;
                            size_q     <= ex_size_i;
                            unsigned_q <= ex_unsigned_i;
                            off_q      <= off_d;
                            state_q    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (data_gnt_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_rvalid_i) begin
                        state_q <= S_IDLE;
                        if (!we_q) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= load_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu_ready_o    = (state_q == S_IDLE);
    assign lsu_busy_o     = (state_q != S_IDLE);
    assign data_req_o     = (state_q == S_REQ);
    assign data_we_o      = we_q;
    assign data_be_o      = be_q;
    assign data_addr_o    = addr_q;
    assign data_wdata_o   = wdata_q;
    assign lsu_rvalid_o   = rvalid_q;
    assign lsu_rdata_o    = rdata_q;
    assign lsu_misalign_o = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_gs_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_gs_lsu
// Brief    : Self-checking bench for gs_lsu: directed cases followed by
//            random ops against a byte-lane reference model of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gs_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_MemRead_i, ex_MemWrite_i, ex_unsigned_i, flush_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic [1:0]  ex_size_i;
    logic        lsu_ready_o, data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        lsu_rvalid_o, lsu_busy_o, lsu_misalign_o;
    logic [31:0] lsu_rdata_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load = 32'h0;

    always #5 clk = ~clk;

    gs_lsu #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_MemRead_i(ex_MemRead_i), .ex_MemWrite_i(ex_MemWrite_i),
        .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_size_i(ex_size_i),
        .ex_unsigned_i(ex_unsigned_i), .flush_i(flush_i),
        .lsu_ready_o(lsu_ready_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_busy_o(lsu_busy_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_misalign_o(lsu_misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || ((a % nbytes(s)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] s);
        logic [3:0] r = 4'h0;
        int off = int'(a % 4);
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + nbytes(s)) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(s)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] s, input bit uns);
        logic [31:0] v = 32'h0;
        int off = int'(a % 4);
        int n = nbytes(s);
        for (int k = 0; k < n; k++) v[8*k +: 8] = rd[8*(off+k) +: 8];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // One complete op from EX through the bus, checking every cycle.
    task automatic do_op(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input bit uns, input int gd, input int rvd,
                         input logic [31:0] rdata);
        bit mis = m_mis(addr, size);
        @(negedge clk);
        chk("idle_ready", {31'b0, lsu_ready_o}, 32'd1);
        chk("idle_busy", {31'b0, lsu_busy_o}, 32'd0);
        ex_valid_i = 1'b1; ex_MemRead_i = rd; ex_MemWrite_i = !rd;
        ex_addr_i = addr; ex_wdata_i = wd; ex_size_i = size; ex_unsigned_i = uns; flush_i = 1'b0;
        @(negedge clk);
        if (mis) begin
            ex_valid_i = 1'b0;
            chk("mis_pulse", {31'b0, lsu_misalign_o}, 32'd1);
            chk("mis_noreq", {31'b0, data_req_o}, 32'd0);
            chk("mis_busy", {31'b0, lsu_busy_o}, 32'd0);
            @(negedge clk);
            chk("mis_pulse_end", {31'b0, lsu_misalign_o}, 32'd0);
            chk("mis_noreq2", {31'b0, data_req_o}, 32'd0);
            return;
        end
        // EX keeps changing after acceptance; the LSU must ignore it.
        ex_valid_i = 1'($urandom); ex_MemRead_i = 1'($urandom); ex_MemWrite_i = 1'($urandom);
        ex_addr_i = $urandom; ex_wdata_i = $urandom; ex_size_i = 2'($urandom);
        flush_i = 1'($urandom);
        chk("no_mis", {31'b0, lsu_misalign_o}, 32'd0);
        for (int i = 0; i <= gd; i++) begin
            data_gnt_i = (i == gd);
            chk("req", {31'b0, data_req_o}, 32'd1);
            chk("we", {31'b0, data_we_o}, {31'b0, !rd});
            chk("be", {28'b0, data_be_o}, {28'b0, m_be(addr, size)});
            chk("addr", data_addr_o, {addr[31:2], 2'b00});
            if (!rd) chk("wdata", data_wdata_o, m_wdata(wd, size));
            chk("req_busy", {31'b0, lsu_busy_o}, 32'd1);
            chk("req_ready", {31'b0, lsu_ready_o}, 32'd0);
            @(negedge clk);
        end
        data_gnt_i = 1'b0;
        for (int j = 0; j <= rvd; j++) begin
            data_rvalid_i = (j == rvd);
            data_rdata_i  = (j == rvd) ? rdata : $urandom;
            chk("wait_noreq", {31'b0, data_req_o}, 32'd0);
            chk("wait_busy", {31'b0, lsu_busy_o}, 32'd1);
            chk("wait_norv", {31'b0, lsu_rvalid_o}, 32'd0);
            @(negedge clk);
        end
        data_rvalid_i = 1'b0; ex_valid_i = 1'b0; flush_i = 1'b0;
        if (rd) last_load = m_load(rdata, addr, size, uns);
        chk("lsu_rvalid", {31'b0, lsu_rvalid_o}, {31'b0, rd});
        chk("lsu_rdata", lsu_rdata_o, last_load);
        chk("done_busy", {31'b0, lsu_busy_o}, 32'd0);
        @(negedge clk);
        chk("rvalid_pulse", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("rdata_hold", lsu_rdata_o, last_load);
    endtask

    initial begin
        rst = 1'b0;
        ex_valid_i = 0; ex_MemRead_i = 0; ex_MemWrite_i = 0; ex_unsigned_i = 0; flush_i = 0;
        ex_addr_i = 0; ex_wdata_i = 0; ex_size_i = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, lsu_ready_o}, 32'd1);
        chk("rst_req", {31'b0, data_req_o}, 32'd0);
        chk("rst_busy", {31'b0, lsu_busy_o}, 32'd0);
        chk("rst_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        chk("rst_be", {28'b0, data_be_o}, 32'd0);
        rst = 1'b1;

        // Directed cases.
        do_op(1, 32'h100, 0, 2'd2, 0, 0, 0, 32'hDEADBEEF);
        chk("lw_value", last_load, 32'hDEADBEEF);
        do_op(1, 32'h103, 0, 2'd0, 0, 0, 0, 32'h80112233);
        chk("lb_value", last_load, 32'hFFFFFF80);
        do_op(1, 32'h103, 0, 2'd0, 1, 1, 1, 32'h80112233);
        chk("lbu_value", last_load, 32'h00000080);
        do_op(1, 32'h102, 0, 2'd1, 1, 0, 2, 32'hABCD1234);
        chk("lhu_value", last_load, 32'h0000ABCD);
        do_op(1, 32'h102, 0, 2'd1, 0, 2, 0, 32'hABCD1234);
        chk("lh_value", last_load, 32'hFFFFABCD);
        do_op(0, 32'h201, 32'h5A, 2'd0, 0, 3, 1, 32'h0);
        do_op(1, 32'h102, 0, 2'd2, 0, 0, 0, 32'h0);
        do_op(0, 32'h101, 32'h1234, 2'd1, 0, 0, 0, 32'h0);
        do_op(1, 32'h100, 0, 2'd3, 0, 0, 0, 32'h0);

        // Stray bus responses while idle are ignored.
        @(negedge clk);
        data_gnt_i = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'h12345678;
        @(negedge clk);
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        chk("stray_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("stray_busy", {31'b0, lsu_busy_o}, 32'd0);
        chk("stray_rdata", lsu_rdata_o, last_load);

        // Flush blocks acceptance, even of a misaligned op.
        ex_valid_i = 1'b1; ex_MemRead_i = 1'b1; ex_MemWrite_i = 1'b0;
        ex_addr_i = 32'h102; ex_size_i = 2'd2; flush_i = 1'b1;
        @(negedge clk);
        ex_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_noreq", {31'b0, data_req_o}, 32'd0);
        chk("flush_nomis", {31'b0, lsu_misalign_o}, 32'd0);
        chk("flush_busy", {31'b0, lsu_busy_o}, 32'd0);

        // Reset in WAIT: abort immediately, then a stray rvalid must be ignored.
        ex_valid_i = 1'b1; ex_MemRead_i = 1'b1; ex_MemWrite_i = 1'b0;
        ex_addr_i = 32'h300; ex_size_i = 2'd2; ex_unsigned_i = 1'b0;
        @(negedge clk);
        ex_valid_i = 1'b0; data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        chk("pre_rst_busy", {31'b0, lsu_busy_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_ready", {31'b0, lsu_ready_o}, 32'd1);
        chk("async_busy", {31'b0, lsu_busy_o}, 32'd0);
        chk("async_req", {31'b0, data_req_o}, 32'd0);
        last_load = 32'h0;
        @(negedge clk);
        rst = 1'b1; data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        chk("post_rst_rvalid", {31'b0, lsu_rvalid_o}, 32'd0);
        chk("post_rst_ready", {31'b0, lsu_ready_o}, 32'd1);
        chk("post_rst_rdata", lsu_rdata_o, last_load);

        // Random ops, mostly aligned.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a = $urandom;
            logic [1:0]  s = 2'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                s = 2'($urandom_range(0, 2));
                a = a & ~(32'(nbytes(s)) - 32'd1);
            end
            do_op(1'($urandom), a, $urandom, s, 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
